pll_lock_sequencer: RTL and testbench

Reset/lock controller for the iCE40 PLL primitive (SB_PLL40_PAD). Runs on the PLL reference clock, holds the PLL in reset for a fixed time, waits for a synchronized and stable LOCK, and only then releases the core reset. It also supervises lock loss, performs bounded retries, and falls back to PLL bypass on failure. It sits between the top-level pad/PLL instance and the global reset tree.

---
 rtl/pll_ctrl_pkg.sv | 64 ++++++
 rtl/sync_2ff.sv | 30 +++
 rtl/pll_lock_sequencer.sv | 136 +++++++++++++
 tb/tb_pll_lock_sequencer.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/pll_ctrl_pkg.sv
// Shared types and constants for the PLL reset/lock sequencer.
// Holds the state enum, default timing and the output decode.
package pll_ctrl_pkg;

  typedef enum logic [2:0] {
    RESET,
    WAIT_LOCK,
    STABLE,
    RUN,
    FAIL
  } pll_seq_state_t;

  typedef struct packed {
    logic resetb;
    logic bypass;
    logic core_rst;
    logic locked;
    logic fail;
  } pll_out_t;

  localparam int PLL_RESET_CYCLES = 16;
  localparam int PLL_LOCK_TIMEOUT = 4096;
  localparam int PLL_LOCK_STABLE  = 64;
  localparam int PLL_MAX_RETRIES  = 3;

  function automatic int pll_cnt_w(
    input int a,
    input int b,
    input int c
  );
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

  function automatic pll_out_t pll_decode(
    input pll_seq_state_t s
  );
    pll_out_t o;
    o.resetb   = 1'b1;
    o.bypass   = 1'b0;
    o.core_rst = 1'b1;
    o.locked   = 1'b0;
    o.fail     = 1'b0;
    case (s)
      RESET: o.resetb = 1'b0;
      RUN: begin
        o.core_rst = 1'b0;
        o.locked   = 1'b1;
      end
      FAIL: begin
        o.resetb   = 1'b0;
        o.bypass   = 1'b1;
        o.core_rst = 1'b0;
        o.fail     = 1'b1;
      end
      default: ;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level.
// Both stages clear to 0 on reset.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic ff1_q, ff1_d;
  logic ff2_q, ff2_d;

  always_comb begin
    ff1_d = d;
    ff2_d = ff1_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ff1_q <= 1'b0;
      ff2_q <= 1'b0;
    end else begin
      ff1_q <= ff1_d;
      ff2_q <= ff2_d;
    end
  end

  assign q = ff2_q;

endmodule

// File: rtl/pll_lock_sequencer.sv
// iCE40 PLL reset/lock sequencer with lock supervision and bypass fallback.
// Define PLL_RETRY_EN to retry timed-out lock attempts up to MAX_RETRIES.
module pll_lock_sequencer
  import pll_ctrl_pkg::*;
#(
  parameter int RESET_CYCLES = PLL_RESET_CYCLES,
  parameter int LOCK_TIMEOUT = PLL_LOCK_TIMEOUT,
  parameter int LOCK_STABLE  = PLL_LOCK_STABLE,
  parameter int MAX_RETRIES  = PLL_MAX_RETRIES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       restart,
  input  logic       pll_lock,
  output logic       pll_resetb,
  output logic       pll_bypass,
  output logic       core_rst,
  output logic       locked,
  output logic       fail,
  output logic [3:0] retry_cnt
);

  localparam int CW = pll_cnt_w(RESET_CYCLES, LOCK_TIMEOUT, LOCK_STABLE);
  localparam logic [CW-1:0] RstLast = CW'(RESET_CYCLES - 1);
  localparam logic [CW-1:0] ToLast  = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] StLast  = CW'(LOCK_STABLE - 1);

  pll_seq_state_t state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  pll_out_t       out_q, out_d;
  logic           lock_s;
  logic           can_retry;
  logic           retry_inc;
  logic           retry_clr;

  sync_2ff u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d   (pll_lock),
    .q   (lock_s)
  );

`ifdef PLL_RETRY_EN
  logic [3:0] retry_q, retry_d;

  assign can_retry = retry_q < 4'(MAX_RETRIES);

  always_comb begin
    retry_d = retry_q;
    if (retry_clr) retry_d = '0;
    else if (retry_inc) retry_d = retry_q + 4'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) retry_q <= '0;
    else retry_q <= retry_d;
  end

  assign retry_cnt = retry_q;
`else
  logic unused_retry;
  assign unused_retry = ^{retry_inc, retry_clr, 4'(MAX_RETRIES)};
  assign can_retry = 1'b0;
  assign retry_cnt = '0;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    retry_inc = 1'b0;
    retry_clr = 1'b0;
    unique case (state_q)
      RESET: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == RstLast) state_d = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        cnt_d = cnt_q + 1'b1;
        // Lock wins over a timeout landing on the same edge.
        if (lock_s) begin
          state_d = STABLE;
        end else if (cnt_q == ToLast) begin
          if (can_retry) begin
            state_d   = RESET;
            retry_inc = 1'b1;
          end else begin
            state_d = FAIL;
          end
        end
      end
      STABLE: begin
        cnt_d = cnt_q + 1'b1;
        if (!lock_s) begin
          state_d = WAIT_LOCK;
        end else if (cnt_q == StLast) begin
          state_d   = RUN;
          retry_clr = 1'b1;
        end
      end
      RUN: begin
        if (!lock_s) begin
          state_d   = RESET;
          retry_clr = 1'b1;
        end
      end
      FAIL: ;
      default: state_d = RESET;
    endcase
    if (restart) begin
      state_d   = RESET;
      retry_inc = 1'b0;
      retry_clr = 1'b1;
    end
    if (restart || (state_d != state_q)) cnt_d = '0;
    out_d = pll_decode(state_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RESET;
      cnt_q   <= '0;
      out_q   <= pll_decode(RESET);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
    end
  end

  assign pll_resetb = out_q.resetb;
  assign pll_bypass = out_q.bypass;
  assign core_rst   = out_q.core_rst;
  assign locked     = out_q.locked;
  assign fail       = out_q.fail;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer (RESET=4, TIMEOUT=16, STABLE=8).
// Outputs are sampled 1 time unit after each rising edge.
module tb_pll_lock_sequencer;

  logic       clk;
  logic       rst;
  logic       restart;
  logic       pll_lock;
  logic       pll_resetb;
  logic       pll_bypass;
  logic       core_rst;
  logic       locked;
  logic       fail;
  logic [3:0] retry_cnt;

  int n_cmp;
  int n_bad;

  // {pll_resetb, pll_bypass, core_rst, locked, fail}
  localparam logic [4:0] O_RST  = 5'b00100;
  localparam logic [4:0] O_WAIT = 5'b10100;
  localparam logic [4:0] O_RUN  = 5'b10010;
  localparam logic [4:0] O_FAIL = 5'b01001;

  pll_lock_sequencer #(
    .RESET_CYCLES (4),
    .LOCK_TIMEOUT (16),
    .LOCK_STABLE  (8),
    .MAX_RETRIES  (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .restart    (restart),
    .pll_lock   (pll_lock),
    .pll_resetb (pll_resetb),
    .pll_bypass (pll_bypass),
    .core_rst   (core_rst),
    .locked     (locked),
    .fail       (fail),
    .retry_cnt  (retry_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4:0] outs();
    return {pll_resetb, pll_bypass, core_rst, locked, fail};
  endfunction

  task automatic check(
    input string      tag,
    input logic [7:0] got,
    input logic [7:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entry edge into RESET (k0) already taken, lock held high.
  task automatic relock(input string tag);
    for (int k = 1; k <= 13; k++) begin
      tick();
      case (k)
        3:  check({tag, "_k3"},  8'(outs()), 8'(O_RST));
        4:  check({tag, "_k4"},  8'(outs()), 8'(O_WAIT));
        12: check({tag, "_k12"}, 8'(outs()), 8'(O_WAIT));
        13: begin
          check({tag, "_k13"}, 8'(outs()), 8'(O_RUN));
          check({tag, "_rc"},  8'(retry_cnt), 8'd0);
        end
        default: ;
      endcase
    end
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    tick();
    restart = 1'b0;
  endtask

  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    rst      = 1'b1;
    restart  = 1'b0;
    pll_lock = 1'b1;
    repeat (3) tick();
    check("rst_outs", 8'(outs()), 8'(O_RST));
    check("rst_rc", 8'(retry_cnt), 8'd0);
    rst = 1'b0;

    relock("nom");

    // Lock loss in RUN: core_rst back on the third edge.
    pll_lock = 1'b0;
    tick();
    tick();
    check("loss_e2", 8'(outs()), 8'(O_RUN));
    tick();
    check("loss_e3", 8'(outs()), 8'(O_RST));
    check("loss_rc", 8'(retry_cnt), 8'd0);
    pll_lock = 1'b1;
    relock("reloc");

    // Two-cycle lock glitch during STABLE.
    pulse_restart();
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 7) pll_lock = 1'b0;
      if (k == 9) pll_lock = 1'b1;
      if (k == 13) check("glt_k13", 8'(outs()), 8'(O_WAIT));
      if (k < 20) check("glt_crst", 8'(core_rst), 8'd1);
      else check("glt_run", 8'(outs()), 8'(O_RUN));
    end

    // Asynchronous reset in the middle of STABLE.
    pulse_restart();
    repeat (6) tick();
    check("ars_pre", 8'(outs()), 8'(O_WAIT));
    #2 rst = 1'b1;
    #1;
    check("ars_outs", 8'(outs()), 8'(O_RST));
    check("ars_rc", 8'(retry_cnt), 8'd0);
    tick();
    rst = 1'b0;
    relock("ars");

    // Lock never arrives: timeouts, retries, then FAIL.
    pll_lock = 1'b0;
    pulse_restart();
    for (int k = 1; k <= 60; k++) begin
      tick();
`ifdef PLL_RETRY_EN
      case (k)
        19: begin
          check("to_k19", 8'(outs()), 8'(O_WAIT));
          check("to_rc19", 8'(retry_cnt), 8'd0);
        end
        20: begin
          check("to_k20", 8'(outs()), 8'(O_RST));
          check("to_rc20", 8'(retry_cnt), 8'd1);
        end
        39: check("to_k39", 8'(outs()), 8'(O_WAIT));
        40: begin
          check("to_k40", 8'(outs()), 8'(O_RST));
          check("to_rc40", 8'(retry_cnt), 8'd2);
        end
        59: check("to_k59", 8'(outs()), 8'(O_WAIT));
        60: begin
          check("to_fail", 8'(outs()), 8'(O_FAIL));
          check("to_rcf", 8'(retry_cnt), 8'd2);
        end
        default: ;
      endcase
`else
      case (k)
        19: check("to_k19", 8'(outs()), 8'(O_WAIT));
        20: begin
          check("to_fail", 8'(outs()), 8'(O_FAIL));
          check("to_rcf", 8'(retry_cnt), 8'd0);
        end
        60: check("to_stick", 8'(outs()), 8'(O_FAIL));
        default: ;
      endcase
`endif
    end

    // FAIL is sticky even with lock back; restart leaves it.
    pll_lock = 1'b1;
    repeat (4) tick();
    check("fail_hold", 8'(outs()), 8'(O_FAIL));
    pulse_restart();
    check("rs_exit", 8'(outs()), 8'(O_RST));
    check("rs_rc", 8'(retry_cnt), 8'd0);
    relock("rs");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
